// File: rtl/vp_attr_delay_line_pkg.sv
// Shared video-pipeline constants and helpers.
// The gfx and text paths clamp their delays with the same function.
package vp_attr_delay_line_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    // Smallest delay a pixel-aligned path can realise (one registered stage).
    localparam int unsigned PIXEL_STEP_MIN = 1;

    // Map a requested delay onto the realisable range [PIXEL_STEP_MIN, max_delay].
    function automatic int unsigned clamp_delay(input int unsigned sel,
                                                input int unsigned max_delay);
        if (sel < PIXEL_STEP_MIN) begin
            return PIXEL_STEP_MIN;
        end
        if (sel > max_delay) begin
            return max_delay;
        end
        return sel;
    endfunction

endpackage

// File: rtl/vp_attr_delay_line_warmup.sv
// Delay-change detector and warm-up counter for the attribute delay line.
// Tracks the active delay and reports when captures must be masked.
module vp_delay_warmup #(
    parameter int unsigned DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ce_i,
    input  logic [DW-1:0] d_req_i,
    output logic [DW-1:0] d_cur_o,
    output logic          warming_o,
    output logic          mask_o
);

    logic [DW-1:0] d_cur_q, d_cur_d;
    logic [DW-1:0] warm_cnt_q, warm_cnt_d;
    logic          change;

    assign change = (d_req_i != d_cur_q);

    // Next-state: a change reloads both registers (no decrement that clock),
    // otherwise the counter steps down once per pixel advance.
    always_comb begin
        d_cur_d    = d_cur_q;
        warm_cnt_d = warm_cnt_q;
        if (change) begin
            d_cur_d    = d_req_i;
            warm_cnt_d = d_req_i;
        end else if (ce_i && (warm_cnt_q != '0)) begin
            warm_cnt_d = warm_cnt_q - DW'(1);
        end
    end

    // State registers; restart at the minimum delay with no warm-up pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_cur_q    <= DW'(1);
            warm_cnt_q <= '0;
        end else begin
            d_cur_q    <= d_cur_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign d_cur_o   = d_cur_q;
    assign warming_o = (warm_cnt_q != '0);
    // The capture on the change clock is masked too, before warm_cnt is loaded.
    assign mask_o    = warming_o | change;

endmodule

// File: rtl/vp_attr_delay_line.sv
// Run-time selectable attribute delay line: aligns attribute words with the
// glyph/gfx fetch path, with stall, flush and warm-up masking of out_valid.
module vp_attr_delay_line
    import vp_attr_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned MAX_DELAY    = 8,
    parameter bit          ZERO_INVALID = TRUE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic                           flush,
    input  logic [$clog2(MAX_DELAY+1)-1:0] delay_sel,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    output logic                           warming
);

    localparam int unsigned DW    = $clog2(MAX_DELAY + 1);
    localparam int unsigned DEPTH = MAX_DELAY - 1;

    logic [DW-1:0]    d_req;
    logic [DW-1:0]    d_cur;
    logic             mask;

    logic [DEPTH-1:0] sr_valid_q;
    logic [WIDTH-1:0] sr_data_q [DEPTH];

    logic             tap_valid;
    logic [WIDTH-1:0] tap_data;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    assign d_req = DW'(clamp_delay(32'(delay_sel), MAX_DELAY));

    vp_delay_warmup #(
        .DW (DW)
    ) u_warmup (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ce_i      (ce),
        .d_req_i   (d_req),
        .d_cur_o   (d_cur),
        .warming_o (warming),
        .mask_o    (mask)
    );

    // Tap select: d=1 bypasses the chain, d=k takes entry k-2.
    always_comb begin
        tap_valid = in_valid;
        tap_data  = in_data;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (d_cur == DW'(k + 2)) begin
                tap_valid = sr_valid_q[k];
                tap_data  = sr_data_q[k];
            end
        end
    end

    // Output next value: mask validity while warming, optionally zero invalid data.
    always_comb begin
        out_valid_d = mask ? FALSE : tap_valid;
        out_data_d  = ((ZERO_INVALID == TRUE) && !out_valid_d) ? '0 : tap_data;
    end

    // Register chain: flush wins over shifting, ce=0 holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_valid_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sr_data_q[k] <= '0;
            end
        end else if (flush) begin
            sr_valid_q <= '0;
            if (ZERO_INVALID == TRUE) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    sr_data_q[k] <= '0;
                end
            end
        end else if (ce) begin
            sr_valid_q[0] <= in_valid;
            sr_data_q[0]  <= in_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sr_valid_q[k] <= sr_valid_q[k-1];
                sr_data_q[k]  <= sr_data_q[k-1];
            end
        end
    end

    // Output register: cleared by flush, loaded on pixel advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= FALSE;
            out_data_q  <= '0;
        end else if (flush) begin
            out_valid_q <= FALSE;
            if (ZERO_INVALID == TRUE) begin
                out_data_q <= '0;
            end
        end else if (ce) begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
